// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce bank.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESSING  = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } deb_state_t;

    localparam int unsigned DEB_SYNC_STAGES = 2;

    // Debounced level is high once a press has qualified, until a release qualifies.
    function automatic logic is_level(input deb_state_t s);
        return (s == PRESSED) || (s == RELEASING);
    endfunction

endpackage

// File: rtl/debounce_if.sv
// Pin-side inputs and debounced outputs of the debounce bank.
interface debounce_if #(
    parameter int unsigned CHANNELS = 4
);
    logic                i_sample_en;
    logic [CHANNELS-1:0] i_button;
    logic [CHANNELS-1:0] o_level;
    logic [CHANNELS-1:0] o_press;
    logic [CHANNELS-1:0] o_release;
    logic [CHANNELS-1:0] o_long_press;

    modport master (
        output i_sample_en, i_button,
        input  o_level, o_press, o_release, o_long_press
    );

    modport slave (
        input  i_sample_en, i_button,
        output o_level, o_press, o_release, o_long_press
    );
endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, qualification FSM and counter.
// Optional hold counter for long_press under `DEBOUNCE_LONG_PRESS_EN.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned LONG_CYCLES   = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sample_en,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long_press
);

    localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if ((STABLE_CYCLES < 2) || (LONG_CYCLES < 1)) begin : g_bad_params
        $error("debounce_chan: STABLE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
    end

    logic [DEB_SYNC_STAGES-1:0] r_sync;
    logic                       w_sync;

    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_press_c;
    logic             w_release_c;

    // Synchroniser runs every clock, independent of the sampling strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEB_SYNC_STAGES-2:0], i_button};
        end
    end

    assign w_sync = r_sync[DEB_SYNC_STAGES-1];

    // Next state: count consecutive samples disagreeing with level, flip on the last one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_c   = 1'b0;
        w_release_c = 1'b0;
        if (i_sample_en) begin
            case (r_state)
                RELEASED: begin
                    if (w_sync) begin
                        w_state_nxt = PRESSING;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                PRESSING: begin
                    if (!w_sync) begin
                        w_state_nxt = RELEASED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        w_press_c   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!w_sync) begin
                        w_state_nxt = RELEASING;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                RELEASING: begin
                    if (w_sync) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = RELEASED;
                        w_cnt_nxt   = '0;
                        w_release_c = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= is_level(w_state_nxt);
            r_press   <= w_press_c;
            r_release <= w_release_c;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned      HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_long_c;
    logic              r_long;

    // Keeps counting through RELEASING so an incomplete release bounce cannot re-arm it.
    always_comb begin
        w_hold_nxt = r_hold;
        w_long_c   = 1'b0;
        if (!r_level) begin
            w_hold_nxt = '0;
        end else if (i_sample_en && (r_hold != HOLD_MAX)) begin
            w_hold_nxt = r_hold + HOLD_W'(1);
            w_long_c   = (r_hold == (HOLD_MAX - HOLD_W'(1)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_hold <= w_hold_nxt;
            r_long <= w_long_c;
        end
    end

    assign o_long_press = r_long;
`else
    assign o_long_press = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button debouncer: CHANNELS independent debounce_chan instances.
// Long-press detection is built only when `DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned LONG_CYCLES   = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    debounce_if.slave  bus
);

    logic [CHANNELS-1:0] w_level;
    logic [CHANNELS-1:0] w_press;
    logic [CHANNELS-1:0] w_release;
    logic [CHANNELS-1:0] w_long;

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_sample_en  (bus.i_sample_en),
            .i_button     (bus.i_button[g]),
            .o_level      (w_level[g]),
            .o_press      (w_press[g]),
            .o_release    (w_release[g]),
            .o_long_press (w_long[g])
        );
    end

    assign bus.o_level      = w_level;
    assign bus.o_press      = w_press;
    assign bus.o_release    = w_release;
    assign bus.o_long_press = w_long;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed + random bench for debounce_bank against a run-length reference model.
module tb_debounce_bank;

    localparam int CH = 4;
    localparam int S  = 16;
    localparam int L  = 100;
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN  = 1'b1;
    localparam int EXP_LONG = 1;
`else
    localparam bit LONG_EN  = 1'b0;
    localparam int EXP_LONG = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    debounce_if #(.CHANNELS(CH)) bus ();

    debounce_bank #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (S),
        .LONG_CYCLES   (L)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [CH-1:0] m_s1, m_s2, m_lvl;
    logic [CH-1:0] e_press, e_rel, e_long;
    int m_run  [CH];
    int m_hold [CH];
    int n_press[CH], n_rel[CH], n_long[CH];
    int t_press[CH], t_long[CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        for (int c = 0; c < CH; c++) begin
            m_run[c]  = 0;
            m_hold[c] = 0;
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after it.
    task automatic step(input logic [CH-1:0] btn, input logic se);
        logic old_lvl;
        bus.i_button    = btn;
        bus.i_sample_en = se;
        @(posedge clk);
        cyc++;
        e_press = '0; e_rel = '0; e_long = '0;
        for (int c = 0; c < CH; c++) begin
            old_lvl = m_lvl[c];
            if (!old_lvl) m_hold[c] = 0;
            if (se) begin
                if (LONG_EN && old_lvl && (m_hold[c] < L)) begin
                    m_hold[c]++;
                    if (m_hold[c] == L) e_long[c] = 1'b1;
                end
                if (m_s2[c] != old_lvl) begin
                    m_run[c]++;
                    if (m_run[c] == S) begin
                        m_run[c] = 0;
                        m_lvl[c] = ~old_lvl;
                        if (old_lvl) e_rel[c] = 1'b1;
                        else         e_press[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
        #1;
        chk("level",      32'(bus.o_level),      32'(m_lvl));
        chk("press",      32'(bus.o_press),      32'(e_press));
        chk("release",    32'(bus.o_release),    32'(e_rel));
        chk("long_press", 32'(bus.o_long_press), 32'(e_long));
        for (int c = 0; c < CH; c++) begin
            if (bus.o_press[c])      begin n_press[c]++; t_press[c] = cyc; end
            if (bus.o_release[c])    n_rel[c]++;
            if (bus.o_long_press[c]) begin n_long[c]++; t_long[c] = cyc; end
        end
    endtask

    // Asynchronous reset between edges; release lands between edges too.
    task automatic do_reset(input logic [CH-1:0] btn);
        bus.i_button    = btn;
        bus.i_sample_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_level", 32'(bus.o_level),      32'd0);
        chk("rst_press", 32'(bus.o_press),      32'd0);
        chk("rst_rel",   32'(bus.o_release),    32'd0);
        chk("rst_long",  32'(bus.o_long_press), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_level", 32'(bus.o_level), 32'd0);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int before_p, before_r, before_l;
        int dur[CH];
        logic [CH-1:0] rb;
        logic se;

        for (int c = 0; c < CH; c++) begin
            n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; t_press[c] = 0; t_long[c] = 0;
        end
        rst_n = 1'b0;
        bus.i_button = 4'hF;
        bus.i_sample_en = 1'b1;
        model_reset();

        // Reset with all buttons held, then full requalification.
        do_reset(4'hF);
        for (int i = 1; i <= 19; i++) begin
            step(4'hF, 1'b1);
            if (i == 17) chk("rq_level_early", 32'(bus.o_level), 32'h0);
            if (i == 18) chk("rq_press_18",    32'(bus.o_press), 32'hF);
            if (i == 19) chk("rq_press_width", 32'(bus.o_press), 32'h0);
        end
        repeat (20) step(4'h0, 1'b1);

        // Glitch of 15 samples is rejected; 16 samples qualifies on edge 18.
        before_p = n_press[0];
        repeat (15) step(4'h1, 1'b1);
        repeat (20) step(4'h0, 1'b1);
        chk("glitch_no_press", 32'(n_press[0] - before_p), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            step((i <= 16) ? 4'h1 : 4'h0, 1'b1);
            if (i == 18) chk("press16_edge18", 32'(bus.o_press[0]), 32'd1);
        end

        // Bounce on release of ch1 yields exactly one release.
        repeat (20) step(4'h2, 1'b1);
        before_p = n_press[1];
        before_r = n_rel[1];
        for (int i = 1; i <= 60; i++) begin
            rb = '0;
            if (i <= 30) rb[1] = 1'(((i - 1) / 3) % 2);
            step(rb, 1'b1);
            if (i == 48) chk("bounce_rel_edge", 32'(bus.o_release[1]), 32'd1);
        end
        chk("bounce_one_rel",   32'(n_rel[1] - before_r),   32'd1);
        chk("bounce_no_press",  32'(n_press[1] - before_p), 32'd0);

        // Strobe every 10th clock on ch2.
        before_p = n_press[2];
        for (int i = 1; i <= 200; i++) begin
            step(4'h4, 1'((i % 10) == 0));
            if (i == 159) chk("strobe_level_pre", 32'(bus.o_level[2]), 32'd0);
            if (i == 160) chk("strobe_press",     32'(bus.o_press[2]), 32'd1);
            if (i == 161) chk("strobe_width",     32'(bus.o_press[2]), 32'd0);
        end
        chk("strobe_one_press", 32'(n_press[2] - before_p), 32'd1);

        // Independence: ch0 press and ch3 release on the same edge.
        repeat (20) step(4'hC, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            step(4'h5, 1'b1);
            if (i == 18) begin
                chk("indep_press",   32'(bus.o_press),   32'h1);
                chk("indep_release", 32'(bus.o_release), 32'h8);
            end
        end
        chk("indep_level", 32'(bus.o_level), 32'h5);

        // Reset in mid-qualification drops the partial count.
        repeat (10) step(4'h7, 1'b1);
        do_reset(4'h7);
        for (int i = 1; i <= 20; i++) begin
            step(4'h7, 1'b1);
            if (i == 17) chk("midrst_level", 32'(bus.o_level), 32'h0);
            if (i == 18) chk("midrst_press", 32'(bus.o_press), 32'h7);
        end

        // Long press on ch0.
        repeat (20) step(4'h0, 1'b1);
        before_l = n_long[0];
        repeat (320) step(4'h1, 1'b1);
        chk("long_count", 32'(n_long[0] - before_l), 32'(EXP_LONG));
        if (LONG_EN) chk("long_delay", 32'(t_long[0] - t_press[0]), 32'd100);

        // Random traffic per channel, strobe tied high then sparse.
        rb = '0;
        for (int c = 0; c < CH; c++) dur[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (dur[c] == 0) begin
                    rb[c]  = 1'($urandom_range(0, 1));
                    dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40))
                                                         : int'($urandom_range(1, 6));
                end
                dur[c]--;
            end
            se = (i < 1500) ? 1'b1 : ($urandom_range(0, 3) == 0);
            step(rb, se);
        end
        repeat (40) step(4'h0, 1'b1);
        chk("final_level", 32'(bus.o_level), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
